// File: rtl/cache_pkg.sv
// cache_pkg: line geometry, refill FSM state encoding and line/index types
// shared by the refill engine and its line assembly buffer.
package cache_pkg;
    localparam int LINE_WIDTH   = 256;
    localparam int WORD_WIDTH   = 32;
    localparam int BEATS        = LINE_WIDTH / WORD_WIDTH;
    localparam int INDEX_WIDTH  = 3;
    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_WRITE, S_DONE} refill_state_e;
    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: beat-indexed line assembly register; each written word lands
// at the slot selected by the running beat count, which wraps after the last beat.
module line_fill_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int BEATS      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          wr_i,
    input  logic [WORD_WIDTH-1:0]         word_i,
    output logic [WORD_WIDTH*BEATS-1:0]   line_o,
    output logic [$clog2(BEATS)-1:0]      cnt_o
);
    logic [WORD_WIDTH*BEATS-1:0] line_q, line_d;
    logic [$clog2(BEATS)-1:0]    cnt_q, cnt_d;

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            line_d = '0;
            cnt_d  = '0;
        end else if (wr_i) begin
            line_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = word_i;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = line_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/cache_line_refill.sv
// cache_line_refill: on a miss, issues one burst read, assembles the returned beats
// into a full line, writes it to the data array in one cycle and signals completion.
module cache_line_refill
    import cache_pkg::*;
#(
    parameter int LINE_WIDTH  = cache_pkg::LINE_WIDTH,
    parameter int INDEX_WIDTH = cache_pkg::INDEX_WIDTH,
    parameter int WORD_WIDTH  = cache_pkg::WORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill_req,
    input  logic [31:0]            fill_addr,
    output logic                   fill_ready,
    output logic                   fill_done,
    output logic                   fill_err,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [31:0]            mem_req_addr,
    output logic [7:0]             mem_req_len,
    input  logic                   mem_resp_valid,
    output logic                   mem_resp_ready,
    input  logic [WORD_WIDTH-1:0]  mem_resp_data,
    input  logic                   mem_resp_last,
    output logic                   da_wen,
    output logic [INDEX_WIDTH-1:0] da_waddr,
    output logic [LINE_WIDTH-1:0]  da_wdata
);
    localparam int BEATS_L  = LINE_WIDTH / WORD_WIDTH;
    localparam int OFFSET_L = $clog2(LINE_WIDTH / 8);
    localparam int BW       = $clog2(BEATS_L);

    refill_state_e          state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic                   err_q, err_d;
    logic                   wen_q;
    logic                   clr, wr, final_beat;
    logic [BW-1:0]          cnt;

    line_fill_buffer #(.WORD_WIDTH(WORD_WIDTH), .BEATS(BEATS_L)) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .wr_i   (wr),
        .word_i (mem_resp_data),
        .line_o (da_wdata),
        .cnt_o  (cnt)
    );

    assign final_beat = cnt == BW'(BEATS_L - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        err_d   = err_q;
        clr     = 1'b0;
        wr      = 1'b0;
        unique case (state_q)
            S_IDLE: if (fill_req) begin
                addr_d  = fill_addr & ~((32'd1 << OFFSET_L) - 32'd1);
                idx_d   = fill_addr[OFFSET_L +: INDEX_WIDTH];
                err_d   = 1'b0;
                clr     = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: if (mem_req_ready) state_d = S_RECV;
            S_RECV: if (mem_resp_valid) begin
                wr = 1'b1;
                // last must coincide exactly with the final beat; collection always runs to a full line
                if (mem_resp_last != final_beat) err_d = 1'b1;
                if (final_beat) state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wen_q   <= state_d == S_WRITE;
        end
    end

    assign fill_ready     = state_q == S_IDLE;
    assign fill_done      = state_q == S_DONE;
    assign fill_err       = err_q;
    assign mem_req_valid  = state_q == S_REQ;
    assign mem_req_addr   = addr_q;
    assign mem_req_len    = 8'(BEATS_L - 1);
    assign mem_resp_ready = state_q == S_RECV;
    assign da_wen         = wen_q;
    assign da_waddr       = idx_q;
endmodule

// File: tb/tb_cache_line_refill.sv
// tb_cache_line_refill: table-driven and randomized fills checked against a
// transaction-level model of the expected line, index, address and error flag.
module tb_cache_line_refill;
    typedef logic [31:0] words_t [8];
    typedef struct {
        logic [31:0] addr;
        int          stall;
        int          gap;
        int          last_at;
        logic [31:0] base;
        logic [31:0] ex_addr;
        logic [2:0]  ex_idx;
        logic        ex_err;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         fill_req = 1'b0, mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_last = 1'b0;
    logic [31:0]  fill_addr = '0, mem_resp_data = '0;
    logic         fill_ready, fill_done, fill_err, mem_req_valid, mem_resp_ready, da_wen;
    logic [31:0]  mem_req_addr;
    logic [7:0]   mem_req_len;
    logic [2:0]   da_waddr;
    logic [255:0] da_wdata, last_line;
    int           checks = 0, errors = 0, wen_cnt = 0;
    vec_t         tbl [5];
    words_t       w;

    cache_line_refill dut (
        .clk(clk), .rst(rst), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_ready(fill_ready), .fill_done(fill_done), .fill_err(fill_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
        .da_wen(da_wen), .da_waddr(da_waddr), .da_wdata(da_wdata)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (da_wen) wen_cnt++;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [255:0] ref_line(input words_t ws);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ws[i];
        return l;
    endfunction

    function automatic words_t mk_words(input logic [31:0] base);
        words_t ws;
        for (int i = 0; i < 8; i++) ws[i] = 32'(base * 32'(i + 1));
        return ws;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input logic [31:0] a, input int stall, input int gap, input int last_at,
                            input words_t ws, input logic [31:0] ex_addr, input logic [2:0] ex_idx,
                            input logic ex_err, input logic hold, input logic [31:0] hold_addr);
        logic [255:0] ex_line;
        int w0;
        ex_line = ref_line(ws);
        w0 = wen_cnt;
        chk("idle_ready", 256'(fill_ready), 256'(1));
        fill_req = 1'b1;
        fill_addr = a;
        step();
        fill_req = hold;
        fill_addr = hold ? hold_addr : $urandom;
        chk("busy_ready", 256'(fill_ready), 256'(0));
        chk("err_cleared", 256'(fill_err), 256'(0));
        for (int i = 0; i <= stall; i++) begin
            chk("req_valid", 256'(mem_req_valid), 256'(1));
            chk("req_addr", 256'(mem_req_addr), 256'(ex_addr));
            chk("req_len", 256'(mem_req_len), 256'(7));
            chk("no_resp_ready_req", 256'(mem_resp_ready), 256'(0));
            mem_req_ready = (i == stall);
            step();
        end
        mem_req_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 1'b0;
                mem_resp_data = $urandom;
                mem_resp_last = 1'($urandom);
                step();
            end
            chk("resp_ready", 256'(mem_resp_ready), 256'(1));
            chk("no_req_recv", 256'(mem_req_valid), 256'(0));
            chk("no_wen_recv", 256'(da_wen), 256'(0));
            mem_resp_valid = 1'b1;
            mem_resp_data = ws[b];
            mem_resp_last = (b == last_at);
            step();
            if (b < 7 && b == last_at) chk("err_early", 256'(fill_err), 256'(1));
        end
        mem_resp_valid = 1'b0;
        mem_resp_last = 1'b0;
        chk("wen", 256'(da_wen), 256'(1));
        chk("waddr", 256'(da_waddr), 256'(ex_idx));
        chk("wdata", da_wdata, ex_line);
        chk("resp_ready_write", 256'(mem_resp_ready), 256'(0));
        chk("done_early", 256'(fill_done), 256'(0));
        step();
        chk("done", 256'(fill_done), 256'(1));
        chk("done_ready", 256'(fill_ready), 256'(0));
        chk("done_wen", 256'(da_wen), 256'(0));
        chk("done_no_req", 256'(mem_req_valid), 256'(0));
        chk("err", 256'(fill_err), 256'(ex_err));
        chk("wen_once", 256'(wen_cnt - w0), 256'(1));
        step();
        chk("done_pulse", 256'(fill_done), 256'(0));
        chk("back_idle", 256'(fill_ready), 256'(1));
        chk("idle_no_req", 256'(mem_req_valid), 256'(0));
        last_line = ex_line;
    endtask

    initial begin
        tbl[0] = '{32'h0000_1234, 0, 0, 7, 32'h1111_1111, 32'h0000_1220, 3'd1, 1'b0};
        tbl[1] = '{32'hABCD_EF5C, 3, 1, 7, 32'h0F1E_2D3C, 32'hABCD_EF40, 3'd2, 1'b0};
        tbl[2] = '{32'h0000_0040, 0, 0, 3, 32'hDEAD_BEEF, 32'h0000_0040, 3'd2, 1'b1};
        tbl[3] = '{32'h0000_00E0, 1, 0, 7, 32'h1234_5678, 32'h0000_00E0, 3'd7, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 2, 2, 8, 32'hCAFE_F00D, 32'hFFFF_FFE0, 3'd7, 1'b1};

        step();
        step();
        chk("rst_ready", 256'(fill_ready), 256'(1));
        chk("rst_done", 256'(fill_done), 256'(0));
        chk("rst_err", 256'(fill_err), 256'(0));
        chk("rst_req_valid", 256'(mem_req_valid), 256'(0));
        chk("rst_resp_ready", 256'(mem_resp_ready), 256'(0));
        chk("rst_wen", 256'(da_wen), 256'(0));
        chk("rst_req_addr", 256'(mem_req_addr), 256'(0));
        chk("rst_waddr", 256'(da_waddr), 256'(0));
        chk("rst_wdata", da_wdata, 256'(0));
        rst = 1'b0;
        step();

        chk("basic_line_const", ref_line(mk_words(32'h1111_1111)),
            256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
        for (int i = 0; i < 5; i++)
            run_fill(tbl[i].addr, tbl[i].stall, tbl[i].gap, tbl[i].last_at, mk_words(tbl[i].base),
                     tbl[i].ex_addr, tbl[i].ex_idx, tbl[i].ex_err, 1'b0, '0);

        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = $urandom;
            step();
            chk("idle_no_ack", 256'(mem_resp_ready), 256'(0));
            chk("idle_no_capture", da_wdata, last_line);
            chk("idle_stays", 256'(fill_ready), 256'(1));
        end
        mem_resp_valid = 1'b0;

        w = mk_words(32'h0101_0101);
        run_fill(32'h0000_0500, 0, 0, 7, w, 32'h0000_0500, 3'd0, 1'b0, 1'b1, 32'h0000_07A4);
        w = mk_words(32'h5A5A_0001);
        run_fill(32'h0000_07A4, 0, 1, 7, w, 32'h0000_07A0, 3'd5, 1'b0, 1'b0, '0);

        begin
            int w0;
            w0 = wen_cnt;
            fill_req = 1'b1;
            fill_addr = 32'h0000_0300;
            step();
            fill_req = 1'b0;
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            for (int b = 0; b < 3; b++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data = 32'hA000_0000 + 32'(b);
                mem_resp_last = (b == 0);
                step();
            end
            mem_resp_valid = 1'b0;
            mem_resp_last = 1'b0;
            chk("pre_rst_err", 256'(fill_err), 256'(1));
            rst = 1'b1;
            #1;
            chk("mid_rst_ready", 256'(fill_ready), 256'(1));
            chk("mid_rst_resp_ready", 256'(mem_resp_ready), 256'(0));
            chk("mid_rst_wdata", da_wdata, 256'(0));
            chk("mid_rst_err", 256'(fill_err), 256'(0));
            chk("mid_rst_req_addr", 256'(mem_req_addr), 256'(0));
            step();
            rst = 1'b0;
            step();
            step();
            chk("mid_rst_no_wen", 256'(wen_cnt - w0), 256'(0));
        end
        w = mk_words(32'h0BAD_F00D);
        run_fill(32'h0000_0320, 1, 0, 7, w, 32'h0000_0320, 3'd1, 1'b0, 1'b0, '0);

        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            int la;
            a = $urandom;
            la = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 7;
            for (int i = 0; i < 8; i++) w[i] = $urandom;
            run_fill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), la, w,
                     {a[31:5], 5'b0}, a[7:5], la != 7, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Refill engine sitting directly upstream of the cache data array.
- On a miss, the cache controller hands it a line address. It issues one burst read to memory and collects 8 x 32-bit response beats into a 256-bit line buffer.
- It then performs a single-cycle full-line write into the data array and reports completion to the controller.
- Moore-style FSM; all data-array outputs are driven from registers.

Parameters:
- LINE_WIDTH, 256, data array line width in bits.
- INDEX_WIDTH, 3, data array address width (8 lines).
- WORD_WIDTH, 32, memory beat width.
- BEATS (localparam), LINE_WIDTH/WORD_WIDTH = 8, beats per line.
- OFFSET_WIDTH (localparam), log2(LINE_WIDTH/8) = 5, byte offset bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fill_req  in  1  controller requests a refill; sampled only when fill_ready=1.
- fill_addr  in  32  miss byte address.
- fill_ready  out  1  high only in IDLE.
- fill_done  out  1  one-cycle pulse after the line is written.
- fill_err  out  1  sticky protocol error flag; cleared on next fill accept.
- mem_req_valid  out  1  burst read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  line-aligned address (low OFFSET_WIDTH bits zero).
- mem_req_len  out  8  beats-1, constant BEATS-1 = 7.
- mem_resp_valid  in  1  response beat valid.
- mem_resp_ready  out  1  high only in RECV.
- mem_resp_data  in  32  response beat.
- mem_resp_last  in  1  final beat marker.
- da_wen  out  1  data array write enable.
- da_waddr  out  3  data array line index.
- da_wdata  out  256  assembled line.

Behaviour:
- Reset (async, any state): state=IDLE, beat_cnt=0, line buffer=0, latched addr=0, fill_err=0.
  - Resulting outputs: fill_ready=1; fill_done, mem_req_valid, mem_resp_ready and da_wen all 0; mem_req_addr=0, da_waddr=0, da_wdata=0.
  - Reset mid-burst aborts with no da_wen. The memory side shares rst, so no orphaned beats are expected.
- IDLE:
  - fill_ready=1.
  - On fill_req: latch {fill_addr[31:5],5'b0}, index=fill_addr[7:5]; clear beat_cnt, buffer and fill_err; go to REQ.
- REQ:
  - mem_req_valid=1, mem_req_addr=latched addr, mem_req_len=7.
  - Hold all three stable until mem_req_ready. Handshake on valid&ready, then go to RECV.
- RECV:
  - mem_resp_ready=1.
  - On each valid&ready beat: buffer[beat_cnt*32 +: 32] <= mem_resp_data; beat_cnt++ (3-bit, wraps after 7).
  - The beat with beat_cnt==7 completes the burst; go to WRITE.
  - mem_resp_last on a beat with beat_cnt!=7 sets fill_err. Collection continues to 8 beats.
  - mem_resp_last=0 on beat 7 also sets fill_err. The line is still written.
  - Beats arrive in increasing address order (beat 0 = bytes 0..3 of the line). No critical-word-first.
- WRITE:
  - Exactly one cycle: da_wen=1, da_waddr=latched index, da_wdata=buffer. Then go to DONE.
- DONE:
  - fill_done=1 for one cycle; fill_ready=0. Then go to IDLE.
  - The array write has already committed, so the controller may read the line when fill_done is seen.
- Latency: from the fill_req accept edge, REQ ≥1 cycle + 8 beats (≥8 cycles) + WRITE 1 + DONE 1.
  - Minimum 11 cycles to fill_done; next request accepted at cycle 12.
- Boundaries:
  - fill_req outside IDLE is ignored (no queueing); the controller must hold it.
  - mem_resp_valid outside RECV is not acknowledged and not captured.
  - Gaps between beats (valid low) stall with no state change.
  - fill_addr changes after accept have no effect.
  - da_wen is never asserted outside WRITE.
  - beat_cnt is 0 on entry to WRITE.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_WIDTH, WORD_WIDTH, BEATS, INDEX_WIDTH, OFFSET_WIDTH;
  - the refill state encoding (IDLE, REQ, RECV, WRITE, DONE; 3-bit);
  - line_t (256-bit) and index_t (3-bit) typedefs.
- One natural sub-module: line_fill_buffer, the beat-indexed 256-bit assembly register with clear/write-word/beat-count. The FSM stays in cache_line_refill.

Test Plan:
- Basic fill: fill_addr=0x0000_1234; mem_req_ready=1; beats 0x11111111..0x88888888 back-to-back, last on beat 8.
  - -> mem_req_addr=0x0000_1220, len=7; da_wen single cycle, da_waddr=1, da_wdata={0x88888888,...,0x22222222,0x11111111}; fill_done 11 cycles after accept; fill_err=0.
- Backpressure and gaps: mem_req_ready low 3 cycles, then beats with valid low between each.
  - -> request fields stable while stalled; capture only on valid&ready; same line result; fill_done delayed accordingly.
- Protocol error: mem_resp_last asserted on beat 4 of 8.
  - -> fill_err=1 from the following cycle; 8 beats still collected; da_wen once.
  - Next fill with fill_addr=0x0000_00E0 (index 7) clears fill_err on accept; da_waddr=7.
- Reset mid-burst: assert rst after 3 beats.
  - -> immediately fill_ready=1, mem_resp_ready=0, da_wen never pulses, buffer=0.
  - A new fill completes normally after release.
- Ignored inputs: fill_req held high during RECV with a different address, and mem_resp_valid pulsed in IDLE.
  - -> no second mem request until after fill_done; no capture in IDLE.
  - The second request is serviced afterward with its own address.
